// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch stage and the fetch-to-decode
// pipeline register.
package fetch_ctrl_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // addi x0,x0,0 -- also the value the pipeline register clears to
    localparam word_t NOP_INST_DEFAULT = 32'h0000_0013;

    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues one imem request at a time,
// holds returned instructions across decode stalls and applies redirects.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000,
    parameter word_t NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] bp_pc,
    input  logic        bp_predict,
    input  logic [31:0] bp_target,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        f2d_en,
    output logic        f2d_flush,
    output logic [31:0] f2d_pc,
    output logic [31:0] f2d_inst,
    output logic        f2d_branch_predict,
    output logic [31:0] f2d_branch_target
);

    fetch_state_t r_state;
    word_t        r_pc;
    word_t        r_req_addr;
    word_t        r_hold_inst;
    word_t        r_hold_pc;
    logic         r_hold_pred;
    word_t        r_hold_tgt;

    fetch_state_t w_state_nxt;
    word_t        w_pc_nxt;
    word_t        w_req_nxt;
    word_t        w_redir_pc;
    word_t        w_seq_pc;
    logic         w_hold_ld;
    logic         w_sel_hold;
    logic         w_req;
    logic         w_en;
    logic         w_flush;

    // State, PC and hold-register update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FETCH;
            r_pc        <= RESET_PC;
            r_req_addr  <= RESET_PC;
            r_hold_inst <= 32'h0000_0000;
            r_hold_pc   <= 32'h0000_0000;
            r_hold_pred <= 1'b0;
            r_hold_tgt  <= 32'h0000_0000;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_req_addr <= w_req_nxt;
            if (w_hold_ld) begin
                r_hold_inst <= imem_rdata;
                r_hold_pc   <= r_req_addr;
                r_hold_pred <= bp_predict;
                r_hold_tgt  <= bp_target;
            end
        end
    end

    // Next-state, next-PC and pipeline-register control
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_req_nxt   = r_req_addr;
        w_hold_ld   = 1'b0;
        w_sel_hold  = 1'b0;
        w_req       = 1'b0;
        w_en        = 1'b0;
        w_flush     = 1'b0;
        w_redir_pc  = align_word(redirect_pc);
        w_seq_pc    = bp_predict ? bp_target : (r_req_addr + 32'd4);
        case (r_state)
            FETCH: begin
                w_req = 1'b1;
                if (redirect) begin
                    w_flush  = 1'b1;
                    w_pc_nxt = w_redir_pc;
                    if (imem_ready) begin
                        w_req_nxt = w_redir_pc;
                    end else begin
                        w_state_nxt = DRAIN;
                    end
                end else if (!imem_ready) begin
                    w_flush = !stall;
                end else if (!stall) begin
                    w_en      = 1'b1;
                    w_pc_nxt  = w_seq_pc;
                    w_req_nxt = w_seq_pc;
                end else begin
                    w_hold_ld   = 1'b1;
                    w_pc_nxt    = w_seq_pc;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    w_flush     = 1'b1;
                    w_pc_nxt    = w_redir_pc;
                    w_req_nxt   = w_redir_pc;
                    w_state_nxt = FETCH;
                end else if (!stall) begin
                    w_en        = 1'b1;
                    w_sel_hold  = 1'b1;
                    w_req_nxt   = r_pc;
                    w_state_nxt = FETCH;
                end else begin
                    w_en = 1'b0;
                end
            end
            DRAIN: begin
                // No cancel on the memory port: keep the old request up
                w_req   = 1'b1;
                w_flush = 1'b1;
                if (redirect) begin
                    w_pc_nxt = w_redir_pc;
                end else begin
                    w_pc_nxt = r_pc;
                end
                if (imem_ready) begin
                    w_req_nxt   = redirect ? w_redir_pc : r_pc;
                    w_state_nxt = FETCH;
                end else begin
                    w_req_nxt = r_req_addr;
                end
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    // Output drive with reset override and bubble data
    always_comb begin
        imem_req           = w_req;
        imem_addr          = r_req_addr;
        f2d_en             = w_en;
        f2d_flush          = w_flush;
        f2d_pc             = 32'h0000_0000;
        f2d_inst           = 32'h0000_0000;
        f2d_branch_predict = 1'b0;
        f2d_branch_target  = 32'h0000_0000;
        if (rst) begin
            imem_req  = 1'b0;
            imem_addr = 32'h0000_0000;
            f2d_en    = 1'b0;
            f2d_flush = 1'b1;
        end else if (w_en && w_sel_hold) begin
            f2d_pc             = r_hold_pc;
            f2d_inst           = r_hold_inst;
            f2d_branch_predict = r_hold_pred;
            f2d_branch_target  = r_hold_tgt;
        end else if (w_en) begin
            f2d_pc             = r_req_addr;
            f2d_inst           = imem_rdata;
            f2d_branch_predict = bp_predict;
            f2d_branch_target  = bp_target;
        end else if (w_flush) begin
            f2d_inst = NOP_INST;
        end else begin
            f2d_inst = 32'h0000_0000;
        end
        bp_pc = imem_addr;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios with literal checks,
// then randomized traffic compared every cycle against a behavioural model.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, imem_ready, bp_predict, stall, redirect;
    logic [31:0] imem_rdata, bp_target, redirect_pc;
    logic        imem_req, f2d_en, f2d_flush, f2d_branch_predict;
    logic [31:0] imem_addr, bp_pc, f2d_pc, f2d_inst, f2d_branch_target;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: "what is fetch doing" as plain flags and values
    logic [31:0] m_pc, m_req;
    bit          m_holding, m_draining;
    logic [31:0] mh_inst, mh_pc, mh_tgt;
    bit          mh_pred;

    fetch_ctrl #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .bp_pc(bp_pc), .bp_predict(bp_predict), .bp_target(bp_target),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .f2d_en(f2d_en), .f2d_flush(f2d_flush), .f2d_pc(f2d_pc),
        .f2d_inst(f2d_inst), .f2d_branch_predict(f2d_branch_predict),
        .f2d_branch_target(f2d_branch_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_wants_req();
        return !rst && !m_holding;
    endfunction

    // Compute expected outputs for the applied inputs, check, then advance the model
    task automatic model_cycle();
        bit          e_req, e_en, e_fl, e_bp;
        logic [31:0] e_addr, e_pc, e_inst, e_bt, rp, seq;
        e_req = 0; e_en = 0; e_fl = 0; e_bp = 0;
        e_addr = 0; e_pc = 0; e_inst = 0; e_bt = 0;
        rp  = redirect_pc & 32'hFFFF_FFFC;
        if (rst) begin
            e_fl = 1;
            m_pc = RST_PC; m_req = RST_PC; m_holding = 0; m_draining = 0;
        end else begin
            e_addr = m_req;
            if (m_holding) begin
                if (redirect) begin
                    e_fl = 1; m_pc = rp; m_req = rp; m_holding = 0;
                end else if (!stall) begin
                    e_en = 1; e_pc = mh_pc; e_inst = mh_inst; e_bp = mh_pred; e_bt = mh_tgt;
                    m_req = m_pc; m_holding = 0;
                end
            end else if (m_draining) begin
                e_req = 1; e_fl = 1;
                if (redirect) m_pc = rp;
                if (imem_ready) begin
                    m_req = m_pc; m_draining = 0;
                end
            end else begin
                e_req = 1;
                seq = bp_predict ? bp_target : m_req + 32'd4;
                if (redirect) begin
                    e_fl = 1; m_pc = rp;
                    if (imem_ready) m_req = rp;
                    else m_draining = 1;
                end else if (!imem_ready) begin
                    e_fl = !stall;
                end else if (!stall) begin
                    e_en = 1; e_pc = m_req; e_inst = imem_rdata; e_bp = bp_predict; e_bt = bp_target;
                    m_pc = seq; m_req = seq;
                end else begin
                    mh_pc = m_req; mh_inst = imem_rdata; mh_pred = bp_predict; mh_tgt = bp_target;
                    m_pc = seq; m_holding = 1;
                end
            end
        end
        chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
        chk("f2d_en", {31'd0, f2d_en}, {31'd0, e_en});
        chk("f2d_flush", {31'd0, f2d_flush}, {31'd0, e_fl});
        if (rst) chk("imem_addr_rst", imem_addr, 32'h0000_0000);
        if (e_req) begin
            chk("imem_addr", imem_addr, e_addr);
            chk("bp_pc", bp_pc, e_addr);
        end
        if (e_en) begin
            chk("f2d_pc", f2d_pc, e_pc);
            chk("f2d_inst", f2d_inst, e_inst);
            chk("f2d_bpred", {31'd0, f2d_branch_predict}, {31'd0, e_bp});
            chk("f2d_btgt", f2d_branch_target, e_bt);
        end
        if (e_fl && !rst) chk("f2d_inst_nop", f2d_inst, NOP);
    endtask

    task automatic step(input bit r, input bit rdy, input logic [31:0] rd, input bit pr,
                        input logic [31:0] tg, input bit st, input bit rd_i, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst = r; imem_ready = rdy; imem_rdata = rd; bp_predict = pr; bp_target = tg;
        stall = st; redirect = rd_i; redirect_pc = rpc;
        @(negedge clk);
        model_cycle();
    endtask

    initial begin
        bit r, rdy, pr, st, rd_i;
        rst = 1; imem_ready = 0; imem_rdata = 0; bp_predict = 0; bp_target = 0;
        stall = 0; redirect = 0; redirect_pc = 0;

        // Reset, then zero-wait sequential fetch
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_rst_req", {31'd0, imem_req}, 32'd0);
        chk("lit_rst_flush", {31'd0, f2d_flush}, 32'd1);
        step(0, 1, 32'hA000_0000, 0, 0, 0, 0, 0);
        chk("lit_addr0", imem_addr, 32'h0000_0100);
        chk("lit_inst0", f2d_inst, 32'hA000_0000);
        step(0, 1, 32'hA000_0001, 0, 0, 0, 0, 0);
        chk("lit_addr1", imem_addr, 32'h0000_0104);
        chk("lit_pc1", f2d_pc, 32'h0000_0104);
        // 0x108 returns under stall, held for three cycles total
        step(0, 1, 32'hDEAD_BEEF, 0, 0, 1, 0, 0);
        chk("lit_addr2", imem_addr, 32'h0000_0108);
        chk("lit_hold_en", {31'd0, f2d_en}, 32'd0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk("lit_hold_req", {31'd0, imem_req}, 32'd0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_rel_inst", f2d_inst, 32'hDEAD_BEEF);
        chk("lit_rel_pc", f2d_pc, 32'h0000_0108);
        // Redirect during a 2-wait request to 0x10C
        step(0, 0, 0, 0, 0, 0, 1, 32'h0000_0403);
        chk("lit_drain_addr", imem_addr, 32'h0000_010C);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_drain_flush", {31'd0, f2d_flush}, 32'd1);
        step(0, 1, 32'hBAD0_BAD0, 0, 0, 0, 0, 0);
        chk("lit_drain_en", {31'd0, f2d_en}, 32'd0);
        // Prediction on 0x400
        step(0, 1, 32'hA000_0002, 1, 32'h0000_0200, 0, 0, 0);
        chk("lit_addr_redir", imem_addr, 32'h0000_0400);
        chk("lit_bp", {31'd0, f2d_branch_predict}, 32'd1);
        chk("lit_bt", f2d_branch_target, 32'h0000_0200);
        // Redirect with stall while holding
        step(0, 1, 32'hA000_0003, 0, 0, 1, 0, 0);
        chk("lit_addr_pred", imem_addr, 32'h0000_0200);
        step(0, 0, 0, 0, 0, 1, 1, 32'h0000_0300);
        chk("lit_hold_redir_fl", {31'd0, f2d_flush}, 32'd1);
        // Redirect into DRAIN then reset mid-drain
        step(0, 0, 0, 0, 0, 0, 1, 32'h0000_0500);
        chk("lit_addr_300", imem_addr, 32'h0000_0300);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_mid_rst_req", {31'd0, imem_req}, 32'd0);
        step(0, 1, 32'hA000_0004, 0, 0, 0, 0, 0);
        chk("lit_restart", imem_addr, 32'h0000_0100);
        // PC wrap at the top of the address space
        step(0, 1, 32'hA000_0005, 0, 0, 0, 1, 32'hFFFF_FFFE);
        step(0, 1, 32'hA000_0006, 0, 0, 0, 0, 0);
        chk("lit_top", imem_addr, 32'hFFFF_FFFC);
        step(0, 1, 32'hA000_0007, 0, 0, 0, 0, 0);
        chk("lit_wrap", imem_addr, 32'h0000_0000);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            r    = ($urandom_range(0, 199) == 0);
            rdy  = model_wants_req() && ($urandom_range(0, 9) < 6);
            pr   = ($urandom_range(0, 3) == 0);
            st   = ($urandom_range(0, 9) < 3);
            rd_i = ($urandom_range(0, 9) == 0);
            step(r, rdy, $urandom, pr, $urandom & 32'hFFFF_FFFC, st, rd_i, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the fetch stage and drives the fetch-to-decode pipeline register's enable, flush and data fields.
- Owns the PC. Issues one instruction-memory request at a time and holds returned instructions while decode stalls.
- Applies branch-predictor redirects and execute-stage mispredict redirects.
- Sits between the instruction memory port, the branch unit, the hazard unit and the fetch_to_decode pipeline register.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INST, 32'h0000_0013, instruction value presented to decode on a bubble (addi x0,x0,0)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
imem_req  out  1  instruction read request; held high until imem_ready
imem_addr  out  32  word-aligned request address; stable while imem_req=1
imem_ready  in  1  response valid this cycle; completes the current request
imem_rdata  in  32  instruction data, valid when imem_ready=1
bp_pc  out  32  PC presented to the branch predictor; equals imem_addr
bp_predict  in  1  predictor says taken for bp_pc (combinational)
bp_target  in  32  predicted target for bp_pc
stall  in  1  decode cannot accept a new instruction this cycle
redirect  in  1  execute-stage mispredict; kill younger instructions
redirect_pc  in  32  corrected PC; bits [1:0] ignored and forced to 0
f2d_en  out  1  pipeline register load enable
f2d_flush  out  1  pipeline register clear-to-bubble; has priority over f2d_en
f2d_pc  out  32  PC of the instruction being loaded
f2d_inst  out  32  instruction being loaded
f2d_branch_predict  out  1  prediction accompanying the instruction
f2d_branch_target  out  32  predicted target accompanying the instruction

Behaviour:
- Registers:
  - pc_q: next PC to fetch.
  - req_addr_q: address of the outstanding request.
  - hold_inst_q, hold_pc_q, hold_pred_q, hold_tgt_q: held instruction and its PC and prediction.
  - state_q.
- States: FETCH, HOLD, DRAIN. Reset sets state=FETCH, pc_q=req_addr_q=RESET_PC and clears the hold registers.
- While rst=1: imem_req=0, f2d_en=0, f2d_flush=1. All other outputs are 0.
- FETCH: imem_req=1, imem_addr=req_addr_q.
  - imem_ready=0: if redirect, go DRAIN and set pc_q=redirect_pc. Otherwise, if stall=0, insert a bubble: f2d_flush=1.
  - imem_ready=1, redirect=1: discard the response, f2d_flush=1, pc_q=req_addr_q=redirect_pc, stay in FETCH.
  - imem_ready=1, stall=0: f2d_en=1 with {req_addr_q, imem_rdata, bp_predict, bp_target}. Next PC = bp_predict ? bp_target : req_addr_q+4, written to pc_q and req_addr_q. Stay in FETCH; back-to-back requests are allowed.
  - imem_ready=1, stall=1: capture the response and prediction into the hold registers, f2d_en=0, f2d_flush=0, go HOLD. The next PC is computed and stored in pc_q.
- HOLD: imem_req=0.
  - redirect=1: drop the held instruction, f2d_flush=1, pc_q=req_addr_q=redirect_pc, go FETCH.
  - stall=0: f2d_en=1 with the hold registers, req_addr_q=pc_q, go FETCH.
  - stall=1: en=0, flush=0.
- DRAIN: imem_req=1 at the old req_addr_q. The memory interface has no cancel, so the request must complete.
  - Decode gets f2d_flush=1 every cycle.
  - A further redirect overwrites pc_q; the newest redirect wins.
  - imem_ready=1: discard the data, req_addr_q=pc_q (or redirect_pc if redirect is also high that cycle), go FETCH.
- Priority for f2d_* every cycle: redirect > stall > normal flow. Redirect flushes even while stall=1.
- When stall=1 and no redirect: f2d_en=0 and f2d_flush=0, so the pipeline register holds.
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0.
- Latency: reset release -> first imem_req in the next cycle. Zero-wait memory gives one instruction per cycle to decode.

Decomposition:
- common_types_pkg: word_t (existing); fetch_state_t enum {FETCH,HOLD,DRAIN}; NOP_INST constant shared with the pipeline register's flush value.
- Single module; no sub-module needed. Next-PC select is inline combinational logic.

Test Plan:
1. Reset with RESET_PC=0x100 and zero-wait memory -> imem_addr 0x100, 0x104, 0x108 on consecutive cycles; f2d_en=1 each cycle with matching f2d_pc/inst.
2. bp_predict=1, bp_target=0x200 on fetch of 0x104 -> f2d_branch_predict=1, target=0x200; next imem_addr=0x200.
3. stall=1 for 3 cycles while 0x108 returns 0xDEADBEEF -> state HOLD, imem_req=0, en=0; on stall release f2d_inst=0xDEADBEEF, pc=0x108; next request 0x10C.
4. 2-wait memory, redirect to 0x403 during an outstanding request to 0x10C -> imem_addr stays 0x10C until ready, flush=1 throughout, data discarded; next imem_addr=0x400.
5. redirect=1 with stall=1 in HOLD -> f2d_flush=1 the same cycle, held instruction never loaded, next fetch at redirect_pc.
6. Reset asserted mid-DRAIN -> next cycle imem_req=0, f2d_flush=1; after release the fetch restarts at RESET_PC.
